hart_selector: RTL and testbench
================================

Name: hart_selector

Overview:
- Consumer end of the global events interface: takes cache_miss / cache_updated / hart_id from the caches and thread_terminated from the pipeline, and drives halt_proc back to the pipeline.
- Implements coarse-grained multithreading across NUM_HARTS harts.
- On a miss by the running hart, it halts and drains the pipeline, then selects the next ready hart round-robin.
- It parks harts that are waiting on a fill and retires harts that have terminated.

Parameters:
- NUM_HARTS, 4, number of hardware threads (1..16).
- DRAIN_CYCLES, 3, cycles halt_proc is held before a switch so in-flight instructions settle (0..15).
- HART_W, $clog2(NUM_HARTS) with a minimum of 1 (derived), width of the active_hart port.

Ports:
- CLK  input  1  system clock; the only clock.
- RST  input  1  reset, synchronous and active-high.
- cache_miss  input  1  one-cycle pulse; a miss is outstanding for hart hart_id.
- cache_updated  input  1  one-cycle pulse; the fill for hart hart_id has completed.
- hart_id  input  32  hart index qualifying cache_miss / cache_updated.
- thread_terminated  input  1  one-cycle pulse; the active hart has retired its terminating instruction.
- halt_proc  output  1  stalls the pipeline fetch/issue.
- active_hart  output  HART_W  index of the hart whose context the pipeline runs.
- hart_switch  output  1  one-cycle pulse when active_hart changes; the pipeline flushes and swaps context.
- all_done  output  1  every hart has terminated.

Behaviour:
- Interface: one clock (CLK); reset is synchronous and active-high (RST).
- Per-hart status register, one of READY / WAITING / DONE.
- Reset values:
  - all harts READY; active_hart=0; state RUN.
  - halt_proc=0, hart_switch=0, all_done=0; drain counter=0.
- RST asserted mid-operation (any state) restores these values on the next edge and discards pending events.
- FSM states: RUN, DRAIN, SELECT, IDLE, FINISH. All outputs are registered.
- RUN (halt_proc=0):
  - thread_terminated → active hart DONE, load drain counter with DRAIN_CYCLES, go DRAIN.
  - Else cache_miss with hart_id==active_hart → active hart WAITING, load counter, go DRAIN.
  - cache_miss and cache_updated together for the active hart → fill already satisfied; no status change, stay RUN.
  - thread_terminated together with cache_miss → terminate wins.
- DRAIN (halt_proc=1):
  - Decrement the counter each cycle.
  - Leave for SELECT in the cycle the counter reads 0, so halt_proc is high for DRAIN_CYCLES+1 cycles before SELECT.
  - With DRAIN_CYCLES=0, DRAIN lasts exactly one cycle.
- SELECT (halt_proc=1), one cycle:
  - Round-robin search from active_hart+1, wrapping modulo NUM_HARTS, with active_hart checked last.
  - First READY hart h found → active_hart<=h, go RUN. hart_switch pulses in that same edge only if h differs from the old active_hart.
  - No READY hart but any WAITING → IDLE.
  - All harts DONE → FINISH.
- IDLE (halt_proc=1):
  - Stay until some hart becomes READY, then go SELECT next cycle.
  - The hart that became READY is selectable in that SELECT.
- FINISH: halt_proc=1, all_done=1; held until reset.
- Status tracking, active in every state:
  - cache_updated for a WAITING hart → READY.
  - cache_updated for a READY or DONE hart → ignored.
- Ignored events:
  - hart_id >= NUM_HARTS on either cache pulse.
  - cache_miss for a non-active hart, and cache_miss outside RUN.
  - thread_terminated outside RUN.
- NUM_HARTS=1:
  - A miss halts until the fill, then resumes hart 0.
  - hart_switch never pulses.
- The pipeline must treat halt_proc rising as taking effect the cycle after the triggering event.

Optional Feature:
- Macro: HART_SELECTOR_PERF_EN.
- When defined, add two outputs:
  - switch_count (32): increments on every hart_switch pulse.
  - idle_cycles (32): increments every cycle in IDLE.
  - Both clear on RST, saturate at all-ones, and never wrap.
- When undefined: ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
1. Reset, NUM_HARTS=4, DRAIN_CYCLES=3: pulse cache_miss with hart_id=0 → halt_proc high 5 cycles (DRAIN 4, SELECT 1); active_hart=1 with a hart_switch pulse at the RUN transition; hart 0 WAITING.
2. Misses for harts 0–3 in turn, no fills → FSM reaches IDLE, halt_proc stays 1. Then cache_updated with hart_id=2 → SELECT next cycle, active_hart=2, one hart_switch pulse.
3. thread_terminated on every hart in sequence → all_done=1 and halt_proc=1 after the last SELECT; a later cache_updated has no effect; RST clears all_done.
4. Boundary events: cache_miss with hart_id=7 (out of range), and cache_miss for a non-active hart → no state change, halt_proc stays 0. cache_miss with cache_updated for the active hart in the same cycle → stays RUN.
5. Assert RST during DRAIN → next cycle halt_proc=0, active_hart=0, all harts READY.
6. With HART_SELECTOR_PERF_EN: run scenario 2 → switch_count equals the number of hart_switch pulses, and idle_cycles equals the cycles spent in IDLE.

Source files
------------

// File: rtl/hart_selector.sv
// rtl/hart_selector.sv - coarse-grained multithreading hart selector with drain and round-robin switch
// Optional HART_SELECTOR_PERF_EN adds saturating switch_count / idle_cycles outputs.
module hart_selector #(
  parameter int NUM_HARTS    = 4,
  parameter int DRAIN_CYCLES = 3,
  localparam int HART_W      = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cache_miss,
  input  logic              cache_updated,
  input  logic [31:0]       hart_id,
  input  logic              thread_terminated,
  output logic              halt_proc,
  output logic [HART_W-1:0] active_hart,
  output logic              hart_switch,
  output logic              all_done
`ifdef HART_SELECTOR_PERF_EN
  ,
  output logic [31:0]       switch_count,
  output logic [31:0]       idle_cycles
`endif
);

  typedef enum logic [2:0] {S_RUN, S_DRAIN, S_SELECT, S_IDLE, S_FINISH} state_e;

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  state_e                        state_q, state_d;
  logic [3:0]                    cnt_q, cnt_d;
  logic [NUM_HARTS-1:0][1:0]     status_q, status_d;
  logic [HART_W-1:0]             active_hart_q, active_d;
  logic                          halt_proc_q, hart_switch_q, all_done_q;
  logic                          switch_d;

  logic                          id_ok;
  logic [HART_W-1:0]             hid;
  logic                          found, any_ready, any_wait;
  logic [HART_W-1:0]             sel;
  int                            idx;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    status_d  = status_q;
    active_d  = active_hart_q;
    switch_d  = 1'b0;
    found     = 1'b0;
    any_ready = 1'b0;
    any_wait  = 1'b0;
    sel       = active_hart_q;
    idx       = 0;
    id_ok     = (hart_id < 32'(NUM_HARTS));
    hid       = hart_id[HART_W-1:0];

    // Fills are tracked in every state; only a parked hart is woken.
    if (cache_updated && id_ok && status_q[hid] == ST_WAIT) begin
      status_d[hid] = ST_READY;
    end

    if (state_q == S_RUN) begin
      if (thread_terminated) begin
        status_d[active_hart_q] = ST_DONE;
        cnt_d   = 4'(DRAIN_CYCLES);
        state_d = S_DRAIN;
      end else if (cache_miss && id_ok && hid == active_hart_q && !cache_updated) begin
        status_d[active_hart_q] = ST_WAIT;
        cnt_d   = 4'(DRAIN_CYCLES);
        state_d = S_DRAIN;
      end
    end

    for (int h = 0; h < NUM_HARTS; h++) begin
      if (status_d[h] == ST_READY) any_ready = 1'b1;
      if (status_d[h] == ST_WAIT)  any_wait  = 1'b1;
    end

    // Round-robin starting after the active hart; active hart is visited last.
    for (int k = 1; k <= NUM_HARTS; k++) begin
      idx = (int'(active_hart_q) + k) % NUM_HARTS;
      if (!found && status_d[idx] == ST_READY) begin
        found = 1'b1;
        sel   = HART_W'(idx);
      end
    end

    case (state_q)
      S_RUN: ;
      S_DRAIN: begin
        if (cnt_q == 4'd0) state_d = S_SELECT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_SELECT: begin
        if (found) begin
          active_d = sel;
          switch_d = (sel != active_hart_q);
          state_d  = S_RUN;
        end else if (any_wait) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_IDLE: begin
        if (any_ready) state_d = S_SELECT;
      end
      S_FINISH: ;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_RUN;
      cnt_q         <= 4'd0;
      status_q      <= '0;
      active_hart_q <= '0;
      halt_proc_q   <= 1'b0;
      hart_switch_q <= 1'b0;
      all_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      status_q      <= status_d;
      active_hart_q <= active_d;
      halt_proc_q   <= (state_d != S_RUN);
      hart_switch_q <= switch_d;
      all_done_q    <= (state_d == S_FINISH);
    end
  end

  assign halt_proc   = halt_proc_q;
  assign active_hart = active_hart_q;
  assign hart_switch = hart_switch_q;
  assign all_done    = all_done_q;

`ifdef HART_SELECTOR_PERF_EN
  logic [31:0] switch_count_q, idle_cycles_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      switch_count_q <= '0;
      idle_cycles_q  <= '0;
    end else begin
      if (switch_d && switch_count_q != '1)              switch_count_q <= switch_count_q + 32'd1;
      if (state_q == S_IDLE && idle_cycles_q != '1)      idle_cycles_q  <= idle_cycles_q + 32'd1;
    end
  end

  assign switch_count = switch_count_q;
  assign idle_cycles  = idle_cycles_q;
`endif

endmodule

// File: tb/tb_hart_selector.sv
// tb/tb_hart_selector.sv - directed self-checking bench for hart_selector (NUM_HARTS=4, DRAIN_CYCLES=3)
module tb_hart_selector;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cache_miss = 1'b0;
  logic        cache_updated = 1'b0;
  logic [31:0] hart_id = 32'd0;
  logic        thread_terminated = 1'b0;
  logic        halt_proc;
  logic [1:0]  active_hart;
  logic        hart_switch;
  logic        all_done;
`ifdef HART_SELECTOR_PERF_EN
  logic [31:0] switch_count;
  logic [31:0] idle_cycles;
`endif

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  hart_selector #(.NUM_HARTS(4), .DRAIN_CYCLES(3)) dut (
    .CLK               (CLK),
    .RST               (RST),
    .cache_miss        (cache_miss),
    .cache_updated     (cache_updated),
    .hart_id           (hart_id),
    .thread_terminated (thread_terminated),
    .halt_proc         (halt_proc),
    .active_hart       (active_hart),
    .hart_switch       (hart_switch),
    .all_done          (all_done)
`ifdef HART_SELECTOR_PERF_EN
    ,
    .switch_count      (switch_count),
    .idle_cycles       (idle_cycles)
`endif
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic pulse_miss(input int id);
    cache_miss = 1'b1;
    hart_id    = 32'(id);
    step();
    cache_miss = 1'b0;
  endtask

  task automatic pulse_upd(input int id);
    cache_updated = 1'b1;
    hart_id       = 32'(id);
    step();
    cache_updated = 1'b0;
  endtask

  task automatic pulse_term();
    thread_terminated = 1'b1;
    step();
    thread_terminated = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_halt", halt_proc, 0);
    check("rst_active", active_hart, 0);
    check("rst_switch", hart_switch, 0);
    check("rst_done", all_done, 0);

    // Miss on hart 0: halt for DRAIN(4)+SELECT(1) cycles, then switch to hart 1
    pulse_miss(0);
    check("t1_halt_c1", halt_proc, 1);
    for (int i = 2; i <= 5; i++) begin
      step();
      check($sformatf("t1_halt_c%0d", i), halt_proc, 1);
      check($sformatf("t1_noswitch_c%0d", i), hart_switch, 0);
    end
    step();
    check("t1_halt_run", halt_proc, 0);
    check("t1_active", active_hart, 1);
    check("t1_switch", hart_switch, 1);
    step();
    check("t1_switch_once", hart_switch, 0);

    // Misses on harts 1,2,3 with no fills: walk to IDLE
    pulse_miss(1);
    repeat (5) step();
    check("t2_active2", active_hart, 2);
    check("t2_switch2", hart_switch, 1);
    pulse_miss(2);
    repeat (5) step();
    check("t2_active3", active_hart, 3);
    check("t2_switch3", hart_switch, 1);
    pulse_miss(3);
    repeat (5) step();
    check("t2_idle_halt", halt_proc, 1);
    check("t2_idle_active", active_hart, 3);
    check("t2_idle_switch", hart_switch, 0);
    repeat (3) step();
    check("t2_idle_hold", halt_proc, 1);
    pulse_upd(6);
    step();
    check("t2_oor_upd_ignored", halt_proc, 1);
    pulse_upd(2);
    check("t2_select_halt", halt_proc, 1);
    check("t2_select_noswitch", hart_switch, 0);
    step();
    check("t2_resume_halt", halt_proc, 0);
    check("t2_resume_active", active_hart, 2);
    check("t2_resume_switch", hart_switch, 1);
`ifdef HART_SELECTOR_PERF_EN
    check("t6_switch_count", switch_count, 4);
    check("t6_idle_cycles", idle_cycles, 6);
`endif
    step();
    check("t2_switch_once", hart_switch, 0);

    // Terminate every hart in turn
    do_reset();
    pulse_term();
    repeat (5) step();
    check("t3_active1", active_hart, 1);
    pulse_term();
    repeat (5) step();
    check("t3_active2", active_hart, 2);
    pulse_term();
    repeat (5) step();
    check("t3_active3", active_hart, 3);
    check("t3_not_done", all_done, 0);
    pulse_term();
    repeat (5) step();
    check("t3_done", all_done, 1);
    check("t3_done_halt", halt_proc, 1);
    check("t3_done_switch", hart_switch, 0);
    pulse_upd(0);
    pulse_term();
    step();
    check("t3_done_hold", all_done, 1);
    check("t3_done_halt_hold", halt_proc, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("t3_rst_done", all_done, 0);
    check("t3_rst_halt", halt_proc, 0);
    check("t3_rst_active", active_hart, 0);

    // Ignored events
    do_reset();
    pulse_miss(7);
    check("t4_oor_miss", halt_proc, 0);
    step();
    check("t4_oor_miss_hold", halt_proc, 0);
    pulse_miss(2);
    step();
    check("t4_nonactive_miss", halt_proc, 0);
    cache_miss    = 1'b1;
    cache_updated = 1'b1;
    hart_id       = 32'd0;
    step();
    cache_miss    = 1'b0;
    cache_updated = 1'b0;
    check("t4_miss_upd", halt_proc, 0);
    step();
    check("t4_miss_upd_hold", halt_proc, 0);
    check("t4_miss_upd_active", active_hart, 0);

    // Reset during DRAIN restores all harts to READY
    do_reset();
    pulse_miss(0);
    repeat (5) step();
    check("t5_active1", active_hart, 1);
    pulse_miss(1);
    step();
    check("t5_drain_halt", halt_proc, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("t5_rst_halt", halt_proc, 0);
    check("t5_rst_active", active_hart, 0);
    check("t5_rst_switch", hart_switch, 0);
    pulse_term();
    repeat (5) step();
    check("t5_hart1_ready", active_hart, 1);
    check("t5_switch", hart_switch, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
